// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared external arithmetic unit (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [3:0]     req_op,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_carry,
  output logic           rsp_neg,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic           alu_s,
  input  logic [N-1:0]   alu_d0,
  input  logic [N-1:0]   alu_d1,
  input  logic [N-1:0]   alu_d2,
  input  logic [N-1:0]   alu_d3,
  input  logic           alu_carry,
  input  logic           alu_msb,
  output logic           busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state_reg, state_next;
  logic [N-1:0] a_reg, b_reg;
  logic [1:0]   op_reg;
  logic         grant_reg;
  logic [N-1:0] result_reg, result_next;
  logic         carry_reg, carry_next;
  logic         neg_reg, neg_next;
  logic         grant_idx;
  logic         accept;
  logic         rsp_done;

  logic [N-1:0] a_lane  [2];
  logic [N-1:0] b_lane  [2];
  logic [1:0]   op_lane [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign a_lane[gi]  = req_a[gi*N +: N];
      assign b_lane[gi]  = req_b[gi*N +: N];
      assign op_lane[gi] = req_op[2*gi +: 2];
    end
  endgenerate

`ifdef ALU_ARB_RR_EN
  logic last_grant_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant_idx;
    end
  end
`endif

  always_comb begin
    grant_idx = 1'b0;
    if (req_valid == 2'b10) begin
      grant_idx = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      grant_idx = ~last_grant_reg;
`else
      grant_idx = 1'b0;
`endif
    end
  end

  // Ready is also gated by reset so nothing is offered while reset is held.
  assign req_ready = (rst && state_reg == IDLE && req_valid != 2'b00) ?
                     {grant_idx, ~grant_idx} : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state_reg == RESP) ? {grant_reg, ~grant_reg} : 2'b00;
  assign rsp_done  = |(rsp_valid & rsp_ready);

  always_comb begin
    result_next = alu_d3;
    carry_next  = 1'b0;
    neg_next    = 1'b0;
    case (op_reg)
      2'b00: begin result_next = alu_d0; carry_next = alu_carry; neg_next = alu_msb; end
      2'b01: begin result_next = alu_d1; carry_next = alu_carry; neg_next = alu_msb; end
      2'b10: begin result_next = alu_d2; carry_next = alu_carry; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'b00;
      grant_reg  <= 1'b0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= a_lane[grant_idx];
        b_reg     <= b_lane[grant_idx];
        op_reg    <= op_lane[grant_idx];
        grant_reg <= grant_idx;
      end
      if (state_reg == EXEC) begin
        result_reg <= result_next;
        carry_reg  <= carry_next;
        neg_reg    <= neg_next;
      end
    end
  end

  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_s      = (state_reg == EXEC) && (op_reg == 2'b01);
  assign rsp_result = result_reg;
  assign rsp_carry  = carry_reg;
  assign rsp_neg    = neg_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural arithmetic unit on the alu_* ports.
module tb_alu_arbiter;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a, req_b;
  logic [3:0]     req_op;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [N-1:0]   rsp_result;
  logic           rsp_carry, rsp_neg;
  logic [N-1:0]   alu_a, alu_b;
  logic           alu_s;
  logic [N-1:0]   alu_d0, alu_d1, alu_d2, alu_d3;
  logic           alu_carry, alu_msb;
  logic           busy;

  int  vectors = 0;
  int  miscompares = 0;
  logic extra_carry = 1'b0;

  always #5 clk = ~clk;

  // External arithmetic unit: carry/msb follow the add/sub selected by alu_s.
  logic [N:0]     sum9;
  logic [2*N-1:0] prod;
  assign sum9      = alu_s ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
  assign prod      = alu_a * alu_b;
  assign alu_d0    = alu_a + alu_b;
  assign alu_d1    = alu_a - alu_b;
  assign alu_d2    = prod[N-1:0];
  assign alu_d3    = '0;
  assign alu_carry = sum9[N] | extra_carry;
  assign alu_msb   = sum9[N-1];

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_neg(rsp_neg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_d3(alu_d3),
    .alu_carry(alu_carry), .alu_msb(alu_msb),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 2'b01; rsp_ready = 2'b00;
    req_a = 16'h0102; req_b = 16'h0304; req_op = 4'b0000;
    step(); step();
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_carry, rsp_neg, alu_a, alu_b, alu_s, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b rv=%b res=%h c=%b n=%b a=%h b=%h s=%b busy=%b, want all 0",
               req_ready, rsp_valid, rsp_result, rsp_carry, rsp_neg, alu_a, alu_b, alu_s, busy);
    end
    rst = 1'b1; req_valid = 2'b00;
    #1;
    $display("reset: outputs ready=%b busy=%b", req_ready, busy);
  endtask

  task automatic do_txn(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic exp_c, input logic exp_n);
    logic [1:0] oh;
    logic       exp_s;
    oh    = (idx == 1) ? 2'b10 : 2'b01;
    exp_s = (op == 2'b01);
    req_a = (idx == 1) ? {a, ~a} : {~a, a};
    req_b = (idx == 1) ? {b, ~b} : {~b, b};
    req_op = (idx == 1) ? {op, ~op} : {~op, op};
    req_valid = oh; rsp_ready = 2'b00;
    #1;
    vectors++;
    if (req_ready !== oh) begin
      miscompares++; $display("FAIL txn_grant: req_ready=%b want %b", req_ready, oh);
    end
    step();
    req_valid = 2'b00;
    #1;
    vectors++;
    if ({busy, req_ready, rsp_valid, alu_s, alu_a, alu_b} !== {1'b1, 2'b00, 2'b00, exp_s, a, b}) begin
      miscompares++;
      $display("FAIL txn_exec: busy=%b ready=%b rv=%b s=%b a=%h b=%h want busy=1 ready=00 rv=00 s=%b a=%h b=%h",
               busy, req_ready, rsp_valid, alu_s, alu_a, alu_b, exp_s, a, b);
    end
    step();
    vectors++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_neg, alu_s} !== {oh, exp_res, exp_c, exp_n, 1'b0}) begin
      miscompares++;
      $display("FAIL txn_resp: rv=%b res=%h c=%b n=%b s=%b want rv=%b res=%h c=%b n=%b s=0",
               rsp_valid, rsp_result, rsp_carry, rsp_neg, alu_s, oh, exp_res, exp_c, exp_n);
    end
    rsp_ready = ~oh;
    step();
    vectors++;
    if ({rsp_valid, rsp_result} !== {oh, exp_res}) begin
      miscompares++;
      $display("FAIL txn_wrong_ready: rv=%b res=%h want rv=%b res=%h", rsp_valid, rsp_result, oh, exp_res);
    end
    rsp_ready = oh;
    step();
    rsp_ready = 2'b00;
    vectors++;
    if ({busy, rsp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL txn_done: busy=%b rv=%b want 0 00", busy, rsp_valid);
    end
    $display("txn: req%0d op=%b a=%h b=%h -> res=%h c=%b n=%b", idx, op, a, b, rsp_result, rsp_carry, rsp_neg);
  endtask

  task automatic test_ops();
    do_txn(0, 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    do_txn(1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b1);
    do_txn(0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    do_txn(0, 2'b01, 8'h30, 8'h10, 8'h20, 1'b0, 1'b0);
    extra_carry = 1'b1;
    do_txn(1, 2'b10, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);
    do_txn(1, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    extra_carry = 1'b0;
    do_txn(0, 2'b10, 8'h50, 8'h30, 8'h00, 1'b0, 1'b0);
    do_txn(0, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    req_a = 16'h0011; req_b = 16'h0022; req_op = 4'b0000;
    req_valid = 2'b01; rsp_ready = 2'b00;
    step();
    req_valid = 2'b11;
    step();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({rsp_valid, rsp_result, rsp_carry, rsp_neg, req_ready, busy} !== {2'b01, 8'h33, 1'b0, 1'b0, 2'b00, 1'b1}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: rv=%b res=%h c=%b n=%b ready=%b busy=%b want 01 33 0 0 00 1",
                 k, rsp_valid, rsp_result, rsp_carry, rsp_neg, req_ready, busy);
      end
      step();
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL hold_release: busy=%b want 0", busy);
    end
    $display("hold: result 33 held for 5 cycles then released, busy=%b", busy);
  endtask

  task automatic test_reset_in_exec();
    req_a = 16'h0100; req_b = 16'h0100; req_op = 4'b0000;
    req_valid = 2'b10; rsp_ready = 2'b00;
    step();
    req_valid = 2'b00;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL rst_exec_enter: busy=%b want 1", busy);
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_carry, rsp_neg, alu_a, alu_b, alu_s, busy} !== '0) begin
      miscompares++;
      $display("FAIL rst_exec_outputs: ready=%b rv=%b res=%h c=%b n=%b a=%h b=%h s=%b busy=%b want all 0",
               req_ready, rsp_valid, rsp_result, rsp_carry, rsp_neg, alu_a, alu_b, alu_s, busy);
    end
    rst = 1'b1; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if ({rsp_valid, busy} !== 3'b000) begin
        miscompares++; $display("FAIL rst_exec_noresp%0d: rv=%b busy=%b want 00 0", k, rsp_valid, busy);
      end
    end
    rsp_ready = 2'b00;
    $display("reset_in_exec: transaction discarded, rv=%b busy=%b", rsp_valid, busy);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    logic [7:0] exp_res;
    rst = 1'b0;
    req_a = 16'h1001; req_b = 16'h2002; req_op = 4'b0000;
    req_valid = 2'b11; rsp_ready = 2'b11;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp = 2'b01;
`endif
      exp_res = (exp == 2'b01) ? 8'h03 : 8'h30;
      #1;
      vectors++;
      if (req_ready !== exp) begin
        miscompares++; $display("FAIL arb_grant%0d: req_ready=%b want %b", k, req_ready, exp);
      end
      step();
      step();
      vectors++;
      if ({rsp_valid, rsp_result} !== {exp, exp_res}) begin
        miscompares++;
        $display("FAIL arb_resp%0d: rv=%b res=%h want rv=%b res=%h", k, rsp_valid, rsp_result, exp, exp_res);
      end
      $display("arb: round %0d granted %b result %h", k, rsp_valid, rsp_result);
      step();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_hold();
    test_reset_in_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
